// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    localparam int unsigned MD_ITERS = 32;

    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Core-to-sequencer bundle: decode request, trap abort, stall and write-back result.
interface muldiv_if;

    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        kill;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val, kill,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, kill,
        output stall, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} register pair: shift-add multiply or
// restoring shift-subtract divide (hi = remainder, lo = quotient/dividend).
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] opnd,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    always_comb begin
        add_sum = {1'b0, hi} + {1'b0, (lo[0] ? opnd : 32'd0)};
        shifted = {hi, lo[31]};
        // Partial remainder stays below 2*divisor, so the low 32 bits of the
        // difference are exact whenever the subtraction fits.
        fits    = (shifted >= {1'b0, opnd});
        diff    = shifted[31:0] - opnd;
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (is_div) begin
            if (fits) begin
                hi_nxt = diff;
                lo_nxt = {lo[30:0], 1'b1};
            end else begin
                hi_nxt = shifted[31:0];
                lo_nxt = {lo[30:0], 1'b0};
            end
        end else begin
            hi_nxt = add_sum[32:1];
            lo_nxt = {add_sum[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: holds the core with stall, presents result for one cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    md_state_t   state, state_nxt;
    logic [2:0]  op;
    logic        sign;
    logic [5:0]  cnt;
    logic [31:0] hi, lo, opnd;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] result_q;
    logic        done_q;

    logic        a_signed, b_signed, a_neg, b_neg, sign_in, is_div_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_res;
    logic        fast_hit;
    logic [31:0] fast_res;
    logic [63:0] val64, neg64;
    logic [31:0] fix_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg     = a_signed & bus.rs1_val[31];
        b_neg     = b_signed & bus.rs2_val[31];
        a_mag     = a_neg ? (~bus.rs1_val + 32'd1) : bus.rs1_val;
        b_mag     = b_neg ? (~bus.rs2_val + 32'd1) : bus.rs2_val;
        sign_in   = (bus.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        is_div_in = bus.funct3[2];

        div_zero  = is_div_in & (bus.rs2_val == '0);
        div_ovf   = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.rs1_val == MD_INT_MIN) && (bus.rs2_val == MD_ALL_ONES);
        special   = div_zero | div_ovf;
        if (div_zero)
            special_res = bus.funct3[1] ? bus.rs1_val : MD_ALL_ONES;
        else
            special_res = bus.funct3[1] ? 32'd0 : MD_INT_MIN;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fm_a, fm_b;
    logic signed [63:0] fm_p;

    // The low 64 bits of the 33x33 signed product are all that MUL/MULH* need.
    assign fm_a     = {a_signed & bus.rs1_val[31], bus.rs1_val};
    assign fm_b     = {b_signed & bus.rs2_val[31], bus.rs2_val};
    assign fm_p     = fm_a * fm_b;
    assign fast_hit = ~bus.funct3[2];
    assign fast_res = (bus.funct3 == F3_MUL) ? fm_p[31:0] : fm_p[63:32];
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    muldiv_step u_step (
        .is_div (op[2]),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_comb begin
        if (!op[2])
            val64 = {hi, lo};
        else
            val64 = {32'd0, (op[1] ? hi : lo)};
        neg64   = sign ? (~val64 + 64'd1) : val64;
        fix_res = ((op == F3_MUL) || op[2]) ? neg64[31:0] : neg64[63:32];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE:
                if (bus.start)
                    state_nxt = (special || fast_hit) ? MD_DONE : MD_CALC;
            MD_CALC:
                if (cnt == 6'(MD_ITERS - 1))
                    state_nxt = MD_FIXUP;
            MD_FIXUP: state_nxt = MD_DONE;
            MD_DONE:  state_nxt = MD_IDLE;
            default:  state_nxt = MD_IDLE;
        endcase
        if (bus.kill)
            state_nxt = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state_nxt == MD_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= '0;
            sign     <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                MD_IDLE:
                    if (bus.start && !bus.kill) begin
                        op   <= bus.funct3;
                        sign <= sign_in;
                        cnt  <= '0;
                        hi   <= '0;
                        lo   <= is_div_in ? a_mag : b_mag;
                        opnd <= is_div_in ? b_mag : a_mag;
                        if (special)
                            result_q <= special_res;
                        else if (fast_hit)
                            result_q <= fast_res;
                    end
                MD_CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 6'd1;
                end
                MD_FIXUP:
                    if (!bus.kill)
                        result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.stall  = ((state == MD_IDLE) && bus.start && !bus.kill) ||
                        (state == MD_CALC) || (state == MD_FIXUP);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0)) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 34;
    endfunction

    // Issue one op at the next cycle t and follow it through t+latency.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp_res;
        int          lat;
        exp_res = ref_model(f, a, b);
        lat     = exp_lat(f, a, b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.funct3  = f;
        bus.rs1_val = a;
        bus.rs2_val = b;
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall@t got %b want 1", name, bus.stall);
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            bus.start   = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.funct3  = 3'($urandom);
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
            @(negedge clk);
            n_checks++;
            if (bus.done !== (k == lat)) begin
                n_fail++;
                $display("FAIL %s done@t+%0d got %b want %b", name, k, bus.done, (k == lat));
            end
            n_checks++;
            if (bus.stall !== (k < lat)) begin
                n_fail++;
                $display("FAIL %s stall@t+%0d got %b want %b", name, k, bus.stall, (k < lat));
            end
        end
        n_checks++;
        if (bus.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result f3=%0d a=%h b=%h got %h want %h", name, f, a, b, bus.result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.funct3  = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++;
        if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        n_checks++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        bus.start = 1'b1;
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_start got %b want 1", bus.stall); end
        bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'b101, 32'd100, 32'd7, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, "remu_100_7");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2");
        run_op(3'b100, 32'd5, 32'd0, "div_by0");
        run_op(3'b111, 32'd5, 32'd0, "remu_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b;
        logic [2:0]  f;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(0, 15)) | {$urandom_range(0, 1) == 1 ? 4'hF : 4'h0, 28'h0};
                default: ;
            endcase
            run_op(f, a, b, "random");
        end
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        prev = bus.result;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.funct3  = 3'b101;
        bus.rs1_val = 32'd100;
        bus.rs2_val = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (k == 10) bus.kill = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL kill_done@t+%0d got %b want 0", k, bus.done); end
        end
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        n_checks++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL kill_stall@t+11 got %b want 0", bus.stall); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL kill_done@t+11 got %b want 0", bus.done); end
        n_checks++;
        if (bus.result !== prev) begin n_fail++; $display("FAIL kill_result got %h want %h", bus.result, prev); end
        run_op(3'b101, 32'd9, 32'd3, "divu_after_kill");
    endtask

    task automatic test_rst_calc();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.funct3  = 3'b100;
        bus.rs1_val = $urandom;
        bus.rs2_val = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_calc cycle %0d done=%b stall=%b want 0/0", k, bus.done, bus.stall);
            end
        end
        n_checks++;
        if (bus.result !== 32'd0) begin n_fail++; $display("FAIL rst_calc_result got %h want 0", bus.result); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(1, 1000)), "back_to_back");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_kill();
        test_rst_calc();
        test_back_to_back();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
